// File: rtl/disp_cmd_scan_if.sv
// Byte-in / display-out bundle of the command-driven display scanner.
// The UART side (master) drives the byte strobe; the scanner (slave) drives
// the shared BCD bus, digit selects and the parser status pulses.
interface disp_cmd_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic [7:0]            rx_byte;
    logic                  rx_done;
    logic [3:0]            bcd_out;
    logic                  blank;
    logic [NUM_DIGITS-1:0] digit_en;
    logic                  frame_ok;
    logic                  cmd_err;
    logic                  busy;

    modport master (
        output rx_byte, rx_done,
        input  bcd_out, blank, digit_en, frame_ok, cmd_err, busy
    );

    modport slave (
        input  rx_byte, rx_done,
        output bcd_out, blank, digit_en, frame_ok, cmd_err, busy
    );
endinterface

// File: rtl/disp_cmd_scan.sv
// Command-driven multiplexed 7-segment controller.
// A framed ASCII parser ("D" + NUM_DIGITS chars + CR/LF, or "C") fills a
// shadow buffer that is committed to the display buffer in a single cycle.
// Independently, a scan scheduler time-shares one BCD bus over all digits,
// with a short dead time at the start of each slot against ghosting.
module disp_cmd_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int DEAD_CLKS    = 2,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic           clk,
    input  logic           rst,
    disp_cmd_scan_if.slave bus
);
    localparam int KW = $clog2(NUM_DIGITS + 1);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int TW = $clog2(TIMEOUT_CLKS);

    localparam logic [7:0] CH_D  = 8'h44;
    localparam logic [7:0] CH_C  = 8'h43;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [1:0] {IDLE, DIGITS, WAIT_END} state_t;

    state_t                     state, state_nxt;
    logic [KW-1:0]              k, k_nxt;
    logic [TW-1:0]              tmo_cnt;
    logic                       tmo_hit;
    logic [NUM_DIGITS-1:0][3:0] disp_val, shad_val;
    logic [NUM_DIGITS-1:0]      disp_blank, shad_blank;
    logic                       preload, store, commit, clear_all;
    logic                       ok_nxt, err_nxt, frame_ok, cmd_err;
    logic                       is_digit, is_space, is_term;
    logic [IW-1:0]              wr_idx;
    logic [PW-1:0]              presc;
    logic [IW-1:0]              scan_idx, scan_idx_nxt;
    logic [3:0]                 bcd_q;
    logic                       blank_q;
    logic [NUM_DIGITS-1:0]      digit_en;

    assign is_digit = (bus.rx_byte >= 8'h30) && (bus.rx_byte <= 8'h39);
    assign is_space = (bus.rx_byte == CH_SP);
    assign is_term  = (bus.rx_byte == CH_CR) || (bus.rx_byte == CH_LF);
    // First character of a frame lands in the leftmost digit.
    assign wr_idx   = IW'(NUM_DIGITS - 1) - k[IW-1:0];
    // Fires on the edge where the idle counter would reach TIMEOUT_CLKS-1.
    assign tmo_hit  = (tmo_cnt == TW'(TIMEOUT_CLKS - 2));

    // Parser next-state and action decode; a byte strobe beats a timeout.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        preload   = 1'b0;
        store     = 1'b0;
        commit    = 1'b0;
        clear_all = 1'b0;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_done && bus.rx_byte == CH_D) begin
                    state_nxt = DIGITS;
                    k_nxt     = '0;
                    preload   = 1'b1;
                end else if (bus.rx_done && bus.rx_byte == CH_C) begin
                    clear_all = 1'b1;
                    ok_nxt    = 1'b1;
                end
            end
            DIGITS: begin
                if (bus.rx_done) begin
                    if (is_digit || is_space) begin
                        store = 1'b1;
                        k_nxt = k + KW'(1);
                        if (k == KW'(NUM_DIGITS - 1)) state_nxt = WAIT_END;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (tmo_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_END: begin
                if (bus.rx_done) begin
                    if (is_term) begin
                        commit = 1'b1;
                        ok_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Parser state register and registered status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            frame_ok <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            k        <= k_nxt;
            frame_ok <= ok_nxt;
            cmd_err  <= err_nxt;
        end
    end

    // Inter-byte idle timer, live only inside a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == IDLE || bus.rx_done || tmo_hit) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // Shadow fill and atomic commit; an abandoned shadow is simply
    // overwritten by the preload of the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shad_val   <= '0;
            shad_blank <= '0;
            disp_val   <= '0;
            disp_blank <= '0;
        end else begin
            if (preload) begin
                shad_val   <= disp_val;
                shad_blank <= disp_blank;
            end else if (store) begin
                // Low nibble of an ASCII digit is its value.
                shad_val[wr_idx]   <= is_space ? 4'd0 : bus.rx_byte[3:0];
                shad_blank[wr_idx] <= is_space;
            end
            if (commit) begin
                disp_val   <= shad_val;
                disp_blank <= shad_blank;
            end else if (clear_all) begin
                disp_blank <= '1;
            end
        end
    end

    assign scan_idx_nxt = (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);

    // Slot scheduler; the bus value is latched once per slot so a commit
    // landing mid-slot never tears the digit being shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc    <= '0;
            scan_idx <= '0;
            bcd_q    <= '0;
            blank_q  <= 1'b0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc    <= '0;
            scan_idx <= scan_idx_nxt;
            bcd_q    <= disp_val[scan_idx_nxt];
            blank_q  <= disp_blank[scan_idx_nxt];
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Digit select, held dark for the first DEAD_CLKS clocks of each slot.
    always_comb begin
        digit_en = '0;
        if (presc >= PW'(DEAD_CLKS)) digit_en[scan_idx] = 1'b1;
    end

    assign bus.bcd_out  = bcd_q;
    assign bus.blank    = blank_q;
    assign bus.digit_en = digit_en;
    assign bus.frame_ok = frame_ok;
    assign bus.cmd_err  = cmd_err;
    assign bus.busy     = (state != IDLE);
endmodule
